// File: rtl/gpu_sched_pkg.sv
// Shared scheduler definitions: default geometry and common index/entry types
// for the warp issue path.
package gpu_sched_pkg;
  localparam int W_DEF  = 32;
  localparam int RW_DEF = 6;
  localparam int D_DEF  = 4;

  typedef logic [$clog2(W_DEF)-1:0] warp_idx_t;
  typedef logic [RW_DEF-1:0]        reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rg;
  } sb_entry_t;
endpackage

// File: rtl/warp_scoreboard_if.sv
// Scoreboard bus: instruction-buffer heads, arbiter grant, writeback strobe
// and the scoreboard's status outputs.
interface warp_scoreboard_if
  import gpu_sched_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int RW = RW_DEF
);
  localparam int WI = $clog2(W);

  logic [W-1:0]    ibuf_valid;
  logic [W*RW-1:0] ibuf_src0;
  logic [W*RW-1:0] ibuf_src1;
  logic [W*RW-1:0] ibuf_dst;
  logic [W-1:0]    ibuf_src0_vld;
  logic [W-1:0]    ibuf_src1_vld;
  logic [W-1:0]    ibuf_dst_vld;
  logic [W-1:0]    grant_mask;
  logic [WI-1:0]   grant_idx;
  logic            wb_valid;
  logic [WI-1:0]   wb_warp;
  logic [RW-1:0]   wb_reg;
  logic [W-1:0]    ready_mask;
  logic [W-1:0]    sb_full;
  logic            sb_idle;
  logic            err_sticky;

  modport master (
    output ibuf_valid, ibuf_src0, ibuf_src1, ibuf_dst,
    output ibuf_src0_vld, ibuf_src1_vld, ibuf_dst_vld,
    output grant_mask, grant_idx, wb_valid, wb_warp, wb_reg,
    input  ready_mask, sb_full, sb_idle, err_sticky
  );

  modport slave (
    input  ibuf_valid, ibuf_src0, ibuf_src1, ibuf_dst,
    input  ibuf_src0_vld, ibuf_src1_vld, ibuf_dst_vld,
    input  grant_mask, grant_idx, wb_valid, wb_warp, wb_reg,
    output ready_mask, sb_full, sb_idle, err_sticky
  );
endinterface

// File: rtl/warp_sb_slice.sv
// One warp's pending-write entries: hazard comparators, lowest-free-slot
// allocation, writeback clear and full/busy status.
module warp_sb_slice #(
  parameter int RW = 6,
  parameter int D  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] src0,
  input  logic [RW-1:0] src1,
  input  logic [RW-1:0] dst,
  input  logic          src0_vld,
  input  logic          src1_vld,
  input  logic          dst_vld,
  input  logic          alloc_en,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_reg,
  output logic          hazard,
  output logic          full,
  output logic          busy,
  output logic          clr_hit
);
  logic [D-1:0]  valid_reg;
  logic [D-1:0]  valid_next;
  logic [RW-1:0] rg_reg [D];
  logic [D-1:0]  hit_src0;
  logic [D-1:0]  hit_src1;
  logic [D-1:0]  hit_dst;
  logic [D-1:0]  clr_match;
  logic [D-1:0]  free_sel;

  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_cmp
      assign hit_src0[gi]  = valid_reg[gi] && (rg_reg[gi] == src0);
      assign hit_src1[gi]  = valid_reg[gi] && (rg_reg[gi] == src1);
      assign hit_dst[gi]   = valid_reg[gi] && (rg_reg[gi] == dst);
      assign clr_match[gi] = valid_reg[gi] && (rg_reg[gi] == clr_reg);
    end
  endgenerate

  always_comb begin
    logic found;
    free_sel = '0;
    found    = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (!valid_reg[i] && !found) begin
        free_sel[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // The clear only touches pre-edge valid entries, so a same-edge allocation
  // into a free slot always survives, even for an identical register.
  assign valid_next = (valid_reg & ~(clr_match & {D{clr_en}})) | (free_sel & {D{alloc_en}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_reg <= '0;
    else        valid_reg <= valid_next;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < D; i++) begin
      if (alloc_en && free_sel[i]) rg_reg[i] <= dst;
    end
  end

  assign hazard  = (src0_vld && |hit_src0) || (src1_vld && |hit_src1) || (dst_vld && |hit_dst);
  assign full    = &valid_reg;
  assign busy    = |valid_reg;
  assign clr_hit = |clr_match;
endmodule

// File: rtl/warp_scoreboard.sv
// Per-warp register scoreboard: decodes grants and writebacks, instantiates
// one slice per warp and forms the issue ready mask and error flag.
module warp_scoreboard
  import gpu_sched_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int RW = RW_DEF,
  parameter int D  = D_DEF
) (
  input logic               clk,
  input logic               rst_n,
  warp_scoreboard_if.slave  sb
);
  localparam int WI = $clog2(W);

  logic [W-1:0] hazard;
  logic [W-1:0] full;
  logic [W-1:0] busy;
  logic [W-1:0] clr_hit;
  logic [W-1:0] alloc_en;
  logic [W-1:0] clr_en;
  logic [W-1:0] grant_expect;
  logic         grant_any;
  logic         grant_ok;
  logic         grant_err;
  logic         wb_err;
  logic         err_reg;

  // A grant is honoured only when the mask is exactly the decoded index.
  assign grant_expect = W'(1) << sb.grant_idx;
  assign grant_any    = |sb.grant_mask;
  assign grant_ok     = grant_any && (sb.grant_mask == grant_expect);
  assign grant_err    = (grant_any && !grant_ok) || (grant_ok && full[sb.grant_idx]);
  assign wb_err       = sb.wb_valid && !clr_hit[sb.wb_warp];

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_warp
      assign alloc_en[gi] = grant_ok && sb.grant_mask[gi] && sb.ibuf_dst_vld[gi] && !full[gi];
      assign clr_en[gi]   = sb.wb_valid && (sb.wb_warp == WI'(gi));

      warp_sb_slice #(.RW(RW), .D(D)) u_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .src0     (sb.ibuf_src0[gi*RW +: RW]),
        .src1     (sb.ibuf_src1[gi*RW +: RW]),
        .dst      (sb.ibuf_dst[gi*RW +: RW]),
        .src0_vld (sb.ibuf_src0_vld[gi]),
        .src1_vld (sb.ibuf_src1_vld[gi]),
        .dst_vld  (sb.ibuf_dst_vld[gi]),
        .alloc_en (alloc_en[gi]),
        .clr_en   (clr_en[gi]),
        .clr_reg  (sb.wb_reg),
        .hazard   (hazard[gi]),
        .full     (full[gi]),
        .busy     (busy[gi]),
        .clr_hit  (clr_hit[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_reg <= 1'b0;
    else        err_reg <= err_reg | grant_err | wb_err;
  end

  // The grant term hides a warp during its own issue cycle.
  assign sb.ready_mask = sb.ibuf_valid & ~hazard & ~full & ~sb.grant_mask;
  assign sb.sb_full    = full;
  assign sb.sb_idle    = ~|busy;
  assign sb.err_sticky = err_reg;
endmodule
